// File: rtl/fifo1_enq_arbiter.sv
// Round-robin enqueue arbiter with burst locking in front of a single-entry FIFO.
// Drives the FIFO enq port, tags each beat with the winner index and counts accepted beats per requester.
module fifo1_enq_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int BURST  = 4,
  parameter int CNT_W  = 16,
  localparam int TAG_W = $clog2(N),
  localparam int BC_W  = $clog2(BURST) + 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ack,
  output logic                in_enq_ena,
  output logic [DATA_W-1:0]   in_enq_v,
  input  logic                in_enq_rdy,
  output logic [TAG_W-1:0]    enq_tag,
  input  logic [TAG_W-1:0]    cnt_sel,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    cnt_value,
  output logic                dbg_locked_o
);

  // Handshake: a requester holds req_valid (and its data) until it sees its
  // req_ack bit; a beat moves to the FIFO only in a cycle where in_enq_ena is
  // high, which requires a winner and in_enq_rdy, and implies exactly one ack.

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e      state_q;
  logic [TAG_W-1:0] owner_q;
  logic [BC_W-1:0]  burst_cnt_q;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  logic             lock_hold;
  logic             rr_found;
  logic [TAG_W-1:0] rr_idx;
  logic             win_valid;
  logic [TAG_W-1:0] win_idx;
  logic             fire;
  int               scan_pos;

  // Rotating scan starting at rr_ptr; the locked owner overrides it while still valid.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_pos = 0;
    for (int k = 0; k < N; k++) begin
      scan_pos = (int'(rr_ptr_q) + k) % N;
      if (!rr_found && req_valid[TAG_W'(scan_pos)]) begin
        rr_found = 1'b1;
        rr_idx   = TAG_W'(scan_pos);
      end
    end
    lock_hold = (state_q == LOCKED) && req_valid[owner_q];
    win_valid = lock_hold || rr_found;
    win_idx   = lock_hold ? owner_q : rr_idx;
  end

  // Outputs are gated by the async reset so an in-flight beat is dropped at once.
  assign fire         = win_valid && in_enq_rdy && !nRST;
  assign in_enq_ena   = fire;
  assign req_ack      = fire ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
  assign in_enq_v     = (win_valid && !nRST) ? req_data[int'(win_idx)*DATA_W +: DATA_W] : '0;
  assign enq_tag      = (win_valid && !nRST) ? win_idx : '0;
  assign dbg_locked_o = (state_q == LOCKED);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (win_idx == TAG_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear && (cnt_sel == TAG_W'(i))) begin
        cnt_d[i] = '0;
      end else if (fire && (win_idx == TAG_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign cnt_value = (int'(cnt_sel) < N) ? cnt_q[cnt_sel] : '0;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Lock FSM; with BURST == 1 the LOCKED state is unreachable.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (fire && (BURST > 1)) begin
            state_q     <= LOCKED;
            owner_q     <= win_idx;
            burst_cnt_q <= BC_W'(1);
          end
        end
        LOCKED: begin
          if (!req_valid[owner_q]) begin
            // Owner dropped: this cycle already arbitrated among the others.
            if (fire) begin
              owner_q     <= win_idx;
              burst_cnt_q <= BC_W'(1);
            end else begin
              state_q     <= UNLOCKED;
              burst_cnt_q <= '0;
            end
          end else if (fire) begin
            if ((burst_cnt_q + 1'b1) == BC_W'(BURST)) begin
              state_q     <= UNLOCKED;
              burst_cnt_q <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= UNLOCKED;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo1_enq_arbiter.md
Name: fifo1_enq_arbiter

Overview:
- Shares the enqueue side of one single-entry 32-bit FIFO (in$enq ENA/RDY interface) among N requesters.
- Round-robin arbitration with optional burst locking, so one requester can push up to BURST consecutive beats.
- Emits the winner's index alongside each enqueue for a companion tag store.
- Keeps per-requester saturating accepted-beat counters for debug and performance readout.

Parameters:
N, 4, number of requesters (2..8)
DATA_W, 32, payload width; matches FIFO enq data width
BURST, 4, max consecutive beats granted to one owner before forced release (1 = no locking)
CNT_W, 16, width of per-requester beat counters

Ports:
CLK  in  1  clock; all state on rising edge
nRST  in  1  asynchronous reset, active-high (asserted = 1), despite the name
req_valid  in  N  requester i has a beat pending; must hold until acked
req_data  in  N*DATA_W  payload; slice i = bits [i*DATA_W +: DATA_W]
req_ack  out  N  one-hot; bit i high in the cycle requester i's beat is accepted
in$enq__ENA  out  1  enqueue strobe to FIFO
in$enq$v  out  DATA_W  enqueue payload
in$enq__RDY  in  1  FIFO can accept this cycle
enq_tag  out  clog2(N)  index of winner; qualified by in$enq__ENA
cnt_sel  in  clog2(N)  counter select
cnt_clear  in  1  clear selected counter at next edge
cnt_value  out  CNT_W  combinational read of selected counter

Behaviour:
- State:
  - lock_valid (1b)
  - owner (clog2 N)
  - burst_cnt (clog2(BURST)+1)
  - rr_ptr (clog2 N)
  - cnt[N]
- Reset (nRST=1, async):
  - lock_valid=0, owner=0, burst_cnt=0, rr_ptr=0, all cnt=0.
  - req_ack, in$enq__ENA forced 0; in$enq$v=0; enq_tag=0.
- Winner selection (combinational, zero latency):
  - If lock_valid and req_valid[owner]: winner=owner.
  - Else: first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
  - None valid: no winner.
- fire = winner exists & in$enq__RDY.
  - in$enq__ENA=fire; req_ack = fire ? onehot(winner) : 0.
  - in$enq$v = data of winner; enq_tag = winner. Both are don't-care when !fire; drive 0 when no winner.
- On fire:
  - rr_ptr <= (winner+1) mod N.
  - cnt[winner]++ saturating at all-ones.
- Lock FSM. States: UNLOCKED (lock_valid=0), LOCKED (lock_valid=1).
  - UNLOCKED, fire, BURST>1: go LOCKED, owner<=winner, burst_cnt<=1.
  - LOCKED, fire: burst_cnt++; if new burst_cnt==BURST, go UNLOCKED.
  - LOCKED, req_valid[owner]=0: go UNLOCKED at edge. The same cycle already arbitrates among the others via rr_ptr; if that beat fires, a new lock starts for the new winner.
  - BURST=1: never LOCKED; pure round-robin.
- Stall (in$enq__RDY=0): no fire; lock, burst_cnt, rr_ptr, counters held, except the owner-drop release above.
- Counters:
  - cnt_clear clears cnt[cnt_sel].
  - Same cycle as a fire to the same index: clear wins, result 0.
  - Clear of a different index does not block the increment.
- Boundaries:
  - rr_ptr wraps N-1 -> 0.
  - Counter at max stays at max.
  - Mid-operation reset drops the lock immediately; any in-flight beat is not acked.

Test Plan:
- Reset, then N=4, all req_valid=1, data i=0x100+i, RDY=1, BURST=1 -> ack order 0,1,2,3,0,...; in$enq$v 0x100,0x101,...; enq_tag matches.
- BURST=4, all valid, RDY=1 -> 4 beats tagged 0, then 4 tagged 1, then 2; cnt[0]=4 after 4 cycles.
- BURST=4, only req0 valid, drops after 2 beats while req2 valid -> the drop cycle fires req2 with no bubble; req2 then locks for up to 4 beats.
- RDY=0 for 3 cycles mid-burst (burst_cnt=2) -> no ENA/ack, state frozen; after RDY=1 exactly 2 more owner beats, then rotation.
- Preload cnt[1] near max (CNT_W=4 build): 20 beats from req1 -> cnt_value(sel=1)=0xF; cnt_clear with sel=1 on a req1 fire -> 0 next cycle.
- Assert nRST mid-lock -> ENA/ack 0 immediately; after release, arbitration restarts at index 0, counters 0.
